// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard/forwarding scoreboard.
package hazard_pkg;

  // Widest register address a slot entry can hold; RA_W must not exceed this.
  localparam int RA_W_MAX = 8;

  // Forward-select code meaning "use register-file data".
  localparam logic [3:0] FWD_RF = 4'd0;

  // One tracked in-flight instruction.
  typedef struct packed {
    logic                valid;
    logic                wen;
    logic                is_load;
    logic [RA_W_MAX-1:0] rd;
  } slot_t;

  // Saturating 32-bit increment used by the event counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_src_resolve.sv
// Resolves one ID source operand: youngest matching slot, readiness check,
// and operand mux. Reports a hazard when the youngest producer is not ready.
module hazard_src_resolve
  import hazard_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RA_W     = 5,
  parameter int DEPTH    = 3,
  parameter int RDY_ALU  = 1,
  parameter int RDY_LOAD = 2
) (
  input  slot_t [DEPTH-1:0]      slots,
  input  logic  [RA_W-1:0]       rs,
  input  logic                   rs_used,
  input  logic  [XLEN-1:0]       rf_data,
  input  logic  [DEPTH*XLEN-1:0] slot_data,
  output logic  [3:0]            fwd_sel,
  output logic  [XLEN-1:0]       operand,
  output logic                   hazard
);

  logic            match_any;
  logic            hit_rdy;
  logic [3:0]      hit_sel;
  logic [XLEN-1:0] hit_data;

  // Scan oldest to youngest so the last match recorded is the youngest slot.
  // Register 0 never matches because rd must be non-zero.
  always_comb begin
    match_any = 1'b0;
    hit_rdy   = 1'b0;
    hit_sel   = FWD_RF;
    hit_data  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (slots[k].valid && slots[k].wen && rs_used &&
          (slots[k].rd != '0) && (slots[k].rd == RA_W_MAX'(rs))) begin
        match_any = 1'b1;
        hit_sel   = 4'(k + 1);
        hit_rdy   = (k >= (slots[k].is_load ? RDY_LOAD : RDY_ALU));
        hit_data  = slot_data[k*XLEN +: XLEN];
      end
    end
  end

  // Forward only a ready producer; otherwise fall back to the register file.
  // When the youngest producer is not ready the register-file value is
  // passed through and is don't-care, since the instruction is held in ID.
  always_comb begin
    hazard = match_any && !hit_rdy;
    if (match_any && hit_rdy) begin
      fwd_sel = hit_sel;
      operand = hit_data;
    end else begin
      fwd_sel = FWD_RF;
      operand = rf_data;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: in-flight destination shift register
// (slot 0 = EX, slot DEPTH-1 = WB), per-source resolution, stall control
// and saturating stall/flush counters.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RA_W     = 5,
  parameter int DEPTH    = 3,
  parameter int NUM_SRC  = 2,
  parameter int RDY_ALU  = 1,
  parameter int RDY_LOAD = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    id_valid,
  input  logic                    id_wen,
  input  logic                    id_is_load,
  input  logic [RA_W-1:0]         id_rd,
  input  logic [NUM_SRC*RA_W-1:0] id_rs,
  input  logic [NUM_SRC-1:0]      id_rs_used,
  input  logic [NUM_SRC*XLEN-1:0] rf_data,
  input  logic [DEPTH*XLEN-1:0]   slot_data,
  input  logic                    flush,
  input  logic                    freeze,
  output logic                    stall_id,
  output logic [NUM_SRC*4-1:0]    fwd_sel,
  output logic [NUM_SRC*XLEN-1:0] operand,
  output logic [31:0]             stall_cnt,
  output logic [31:0]             flush_cnt
);

  slot_t [DEPTH-1:0]  slots;
  slot_t              slot_in;
  logic [NUM_SRC-1:0] src_hazard;

  // One resolver per source operand.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_src_resolve #(
      .XLEN     (XLEN),
      .RA_W     (RA_W),
      .DEPTH    (DEPTH),
      .RDY_ALU  (RDY_ALU),
      .RDY_LOAD (RDY_LOAD)
    ) u_resolve (
      .slots     (slots),
      .rs        (id_rs[i*RA_W +: RA_W]),
      .rs_used   (id_rs_used[i]),
      .rf_data   (rf_data[i*XLEN +: XLEN]),
      .slot_data (slot_data),
      .fwd_sel   (fwd_sel[i*4 +: 4]),
      .operand   (operand[i*XLEN +: XLEN]),
      .hazard    (src_hazard[i])
    );
  end

  // Stall on any unready producer; a flush kills the ID instruction so it
  // overrides the stall. A stalled or flushed instruction enters as a bubble.
  always_comb begin
    stall_id        = id_valid && !flush && (|src_hazard);
    slot_in.valid   = id_valid && !stall_id && !flush;
    slot_in.wen     = id_wen;
    slot_in.is_load = id_is_load;
    slot_in.rd      = RA_W_MAX'(id_rd);
  end

  // Slot shift register and counters; reset beats freeze, freeze holds all.
  always_ff @(posedge clk) begin
    if (reset) begin
      slots     <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!freeze) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        slots[k] <= slots[k-1];
      end
      slots[0] <= slot_in;
      if (stall_id) stall_cnt <= sat_inc(stall_cnt);
      if (flush)    flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: the driver applies one ID cycle per clock and
// pushes the reference model's prediction; a monitor pops and compares on
// the falling edge. The model tracks in-flight instructions by age.
module tb_hazard_scoreboard;
  localparam int XLEN     = 32;
  localparam int RA_W     = 5;
  localparam int DEPTH    = 3;
  localparam int NUM_SRC  = 2;
  localparam int RDY_ALU  = 1;
  localparam int RDY_LOAD = 2;

  logic                    clk;
  logic                    reset;
  logic                    id_valid;
  logic                    id_wen;
  logic                    id_is_load;
  logic [RA_W-1:0]         id_rd;
  logic [NUM_SRC*RA_W-1:0] id_rs;
  logic [NUM_SRC-1:0]      id_rs_used;
  logic [NUM_SRC*XLEN-1:0] rf_data;
  logic [DEPTH*XLEN-1:0]   slot_data;
  logic                    flush;
  logic                    freeze;
  logic                    stall_id;
  logic [NUM_SRC*4-1:0]    fwd_sel;
  logic [NUM_SRC*XLEN-1:0] operand;
  logic [31:0]             stall_cnt;
  logic [31:0]             flush_cnt;

  hazard_scoreboard #(
    .XLEN(XLEN), .RA_W(RA_W), .DEPTH(DEPTH), .NUM_SRC(NUM_SRC),
    .RDY_ALU(RDY_ALU), .RDY_LOAD(RDY_LOAD)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_wen(id_wen),
    .id_is_load(id_is_load), .id_rd(id_rd), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .rf_data(rf_data), .slot_data(slot_data),
    .flush(flush), .freeze(freeze), .stall_id(stall_id), .fwd_sel(fwd_sel),
    .operand(operand), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic            wen;
    logic            is_load;
    logic [RA_W-1:0] rd;
    int              age;   // cycles since leaving ID: 0 = EX
  } instr_t;

  typedef struct packed {
    logic                    stall;
    logic                    chk_fwd;
    logic [NUM_SRC*4-1:0]    fwd;
    logic [NUM_SRC*XLEN-1:0] opnd;
    logic [31:0]             sc;
    logic [31:0]             fc;
  } exp_t;

  instr_t      inflight[$];
  logic [31:0] m_sc, m_fc;
  logic        cur_stall;
  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  // Prediction for the current inputs and in-flight set.
  function automatic exp_t predict();
    exp_t e;
    logic any_hz;
    any_hz = 1'b0;
    e.fwd  = '0;
    e.opnd = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      logic [RA_W-1:0] rs;
      int best;
      int sel;
      logic [XLEN-1:0] op;
      rs   = id_rs[i*RA_W +: RA_W];
      sel  = 0;
      op   = rf_data[i*XLEN +: XLEN];
      best = -1;
      if (id_rs_used[i] && rs != 0) begin
        for (int j = 0; j < inflight.size(); j++) begin
          if (inflight[j].wen && inflight[j].rd == rs &&
              (best < 0 || inflight[j].age < inflight[best].age))
            best = j;
        end
        if (best >= 0) begin
          int age;
          age = inflight[best].age;
          if (age >= (inflight[best].is_load ? RDY_LOAD : RDY_ALU)) begin
            sel = age + 1;
            op  = slot_data[age*XLEN +: XLEN];
          end else begin
            any_hz = 1'b1;
          end
        end
      end
      e.fwd[i*4 +: 4]     = 4'(sel);
      e.opnd[i*XLEN +: XLEN] = op;
    end
    e.stall   = id_valid && !flush && any_hz;
    e.chk_fwd = !any_hz;
    e.sc      = m_sc;
    e.fc      = m_fc;
    return e;
  endfunction

  // Effect of the clock edge on the model, using the inputs held at the edge.
  task automatic model_edge();
    if (reset) begin
      inflight.delete();
      m_sc = 0;
      m_fc = 0;
    end else if (!freeze) begin
      instr_t nxt[$];
      foreach (inflight[j]) begin
        instr_t t;
        t = inflight[j];
        t.age++;
        if (t.age < DEPTH) nxt.push_back(t);
      end
      inflight = nxt;
      if (cur_stall && m_sc != 32'hFFFF_FFFF) m_sc++;
      if (flush && m_fc != 32'hFFFF_FFFF) m_fc++;
      if (id_valid && !cur_stall && !flush) begin
        instr_t n;
        n.wen = id_wen; n.is_load = id_is_load; n.rd = id_rd; n.age = 0;
        inflight.push_back(n);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic w, input logic ld,
                      input logic [RA_W-1:0] rd, input logic [RA_W-1:0] rs0,
                      input logic [RA_W-1:0] rs1, input logic [1:0] used,
                      input logic fl, input logic fz, input logic rst);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    id_valid   = v;
    id_wen     = w;
    id_is_load = ld;
    id_rd      = rd;
    id_rs      = {rs1, rs0};
    id_rs_used = used;
    flush      = fl;
    freeze     = fz;
    reset      = rst;
    rf_data    = {$urandom, $urandom};
    slot_data  = {$urandom, $urandom, $urandom};
    e = predict();
    cur_stall = e.stall;
    exp_q.push_back(e);
  endtask

  task automatic nop(input logic rst);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, 2'b00, 1'b0, 1'b0, rst);
  endtask

  task automatic rand_step();
    step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
         $urandom_range(0, 2) == 0, RA_W'($urandom_range(0, 7)),
         RA_W'($urandom_range(0, 7)), RA_W'($urandom_range(0, 7)),
         2'($urandom_range(0, 3)), $urandom_range(0, 7) == 0,
         $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("stall_id", 64'(stall_id), 64'(e.stall));
        check("stall_cnt", 64'(stall_cnt), 64'(e.sc));
        check("flush_cnt", 64'(flush_cnt), 64'(e.fc));
        if (e.chk_fwd) begin
          for (int i = 0; i < NUM_SRC; i++) begin
            check($sformatf("fwd_sel%0d", i), 64'(fwd_sel[i*4 +: 4]),
                  64'(e.fwd[i*4 +: 4]));
            check($sformatf("operand%0d", i), 64'(operand[i*XLEN +: XLEN]),
                  64'(e.opnd[i*XLEN +: XLEN]));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; id_valid = 1'b0; id_wen = 1'b0; id_is_load = 1'b0;
    id_rd = '0; id_rs = '0; id_rs_used = '0; rf_data = '0; slot_data = '0;
    flush = 1'b0; freeze = 1'b0; cur_stall = 1'b0; m_sc = 0; m_fc = 0;

    nop(1'b1); nop(1'b1); nop(1'b0);

    // ALU then dependent ALU: one stall, then forward from slot 1
    step(1, 1, 0, 5, 0, 0, 2'b00, 0, 0, 0);
    step(1, 1, 0, 6, 5, 0, 2'b01, 0, 0, 0);
    step(1, 1, 0, 6, 5, 0, 2'b01, 0, 0, 0);
    nop(0); nop(0); nop(0);

    // Load-use: two stalls, then forward from slot 2
    step(1, 1, 1, 8, 0, 0, 2'b00, 0, 0, 0);
    repeat (3) step(1, 1, 0, 9, 8, 0, 2'b01, 0, 0, 0);
    nop(0); nop(0); nop(0);

    // Double hazard on r3: youngest producer wins
    step(1, 1, 0, 3, 0, 0, 2'b00, 0, 0, 0);
    step(1, 1, 0, 3, 0, 0, 2'b00, 0, 0, 0);
    nop(0);
    step(1, 0, 0, 0, 3, 3, 2'b11, 0, 0, 0);
    nop(0); nop(0); nop(0);

    // Writes to r0 never forward
    step(1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    nop(0);
    step(1, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0);
    nop(0); nop(0); nop(0);

    // Flush overriding a load-use stall
    step(1, 1, 1, 9, 0, 0, 2'b00, 0, 0, 0);
    step(1, 1, 0, 4, 9, 0, 2'b01, 1, 0, 0);
    nop(0); nop(0); nop(0);

    // Freeze held three cycles during a stall, then release
    step(1, 1, 1, 10, 0, 0, 2'b00, 0, 0, 0);
    step(1, 1, 0, 4, 0, 10, 2'b10, 0, 0, 0);
    repeat (3) step(1, 1, 0, 4, 0, 10, 2'b10, 0, 1, 0);
    repeat (3) step(1, 1, 0, 4, 0, 10, 2'b10, 0, 0, 0);
    nop(0); nop(0); nop(0);

    // Reset asserted mid-stall
    step(1, 1, 1, 11, 0, 0, 2'b00, 0, 0, 0);
    step(1, 1, 0, 4, 11, 0, 2'b01, 0, 0, 0);
    step(1, 1, 0, 4, 11, 0, 2'b01, 0, 0, 1);
    step(1, 1, 0, 4, 11, 0, 2'b01, 0, 0, 0);
    nop(0); nop(0); nop(0);

    // Randomized traffic
    repeat (3000) rand_step();
    nop(0); nop(0);

    repeat (4) @(posedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
